// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential MIPS divider: FSM encoding, default
// operand width and the fill value used for the divide-by-zero quotient.
package div_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Divide-by-zero quotient is all ones; the fill bit is replicated to WIDTH.
    localparam logic DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude and keep the difference only without borrow.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_msb;

    // The shifted remainder can reach 2*divisor-1, hence the extra guard bit
    // above the WIDTH+1 trial so the borrow is unambiguous.
    always_comb begin
        shifted  = {rem, din};
        trial    = {1'b0, shifted} - {2'b00, divisor_mag};
        q_bit    = ~trial[WIDTH+1];
        next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    // When the trial is kept it is below the divisor, so this bit is always zero.
    assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divider for DIV/DIVU: one quotient bit per clock on
// operand magnitudes, followed by a single sign fix-up cycle.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             signed_q, signed_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;

    logic             in_dvd_neg, in_dvs_neg;
    logic [WIDTH-1:0] in_dvd_mag, in_dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_q),
        .din         (quo_q[WIDTH-1]),
        .divisor_mag (dmag_q),
        .next_rem    (step_rem),
        .q_bit       (step_q)
    );

    // 0x80..0 negates to itself, which is exactly its unsigned magnitude.
    always_comb begin
        in_dvd_neg = is_signed & dividend[WIDTH-1];
        in_dvs_neg = is_signed & divisor[WIDTH-1];
        in_dvd_mag = in_dvd_neg ? (WIDTH'(0) - dividend) : dividend;
        in_dvs_mag = in_dvs_neg ? (WIDTH'(0) - divisor)  : divisor;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        signed_d    = signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        dz_pend_d   = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dz_pend_q) begin
                    // Zero divisor: quo_q carries the raw dividend for one cycle.
                    quotient_d  = {WIDTH{DIV0_Q_FILL}};
                    remainder_d = quo_q;
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                end else if (start) begin
                    signed_d  = is_signed;
                    dvd_neg_d = in_dvd_neg;
                    dvs_neg_d = in_dvs_neg;
                    rem_d     = '0;
                    count_d   = '0;
                    if (divisor == '0) begin
                        quo_d     = dividend;
                        dz_pend_d = 1'b1;
                    end else begin
                        quo_d   = in_dvd_mag;
                        dmag_d  = in_dvs_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d   = step_rem;
                quo_d   = {quo_q[WIDTH-2:0], step_q};
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (WIDTH'(0) - quo_q) : quo_q;
                remainder_d = (signed_q && dvd_neg_q) ? (WIDTH'(0) - rem_q) : rem_q;
                div_zero_d  = 1'b0;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            signed_q    <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dz_pend_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            signed_q    <= signed_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            dz_pend_q   <= dz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE) || dz_pend_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at each accepted
// start and compared, with latency, when done pulses.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           t0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    // Reference: 64-bit integer division (truncating, remainder follows dividend).
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint xa, xb, qq, rr;
        e.t0 = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            if (s) begin
                xa = longint'($signed(a));
                xb = longint'($signed(b));
            end else begin
                xa = longint'({32'd0, a});
                xb = longint'({32'd0, b});
            end
            qq    = xa / xb;
            rr    = xa % xb;
            e.q   = qq[W-1:0];
            e.r   = rr[W-1:0];
            e.dz  = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    // Call just after a negedge; start is held across one rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e = model(a, b, s);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.t0  = cyc;
        sb.push_back(e);
        $display("issue %s 0x%h / 0x%h at cycle %0d", s ? "DIV " : "DIVU", a, b, cyc);
        check("busy_after_start", W'(busy), 1);
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", W'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("done_width", W'(done_prev), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_zero", W'(div_zero), W'(mon_e.dz));
                check("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
                check("busy_at_done", W'(busy), 0);
                $display("done q=0x%h r=0x%h dz=%0d latency=%0d", quotient, remainder, div_zero, cyc - mon_e.t0);
            end
        end
        done_prev <= done;
    end

    logic [W-1:0] dir_a [12] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF,
                                 32'd5, 32'd9, 32'd5, 32'd9, 32'h80000000, 32'd0, 32'hFFFFFFF0};
    logic [W-1:0] dir_b [12] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,
                                 32'd0, 32'd3, 32'd0, 32'd3, 32'hFFFFFFFF, 32'd5, 32'h00000003};
    logic         dir_s [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int n;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", W'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(dir_a[i], dir_b[i], dir_s[i]);
            wait_idle();
        end

        // A second start ten cycles into an op must be dropped.
        issue(32'd1000, 32'd10, 1'b0);
        repeat (9) @(negedge clk);
        dividend  = 32'd77;
        divisor   = 32'd5;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Start raised in the done cycle is accepted.
        issue(32'd123456, 32'd789, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done) begin
            issue(32'd1000000, 32'd3, 1'b0);
        end else begin
            check("b2b_done_timeout", W'(n), 0);
        end
        wait_idle();

        // Reset mid-operation discards the op and clears the outputs.
        issue(32'd5000, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", W'(busy), 0);
        check("midrst_done", W'(done), 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_zero", W'(div_zero), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd9, 32'd3, 1'b1);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(1, 50)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            issue(ra, rb, 1'(i % 2));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
